// File: rtl/reg_access_sequencer_pkg.sv
// Shared sequencer definitions: opcodes, FSM states, instruction fields.
// Used by the sequencer, its ALU and future register-file/decoder blocks.
package reg_access_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EXEC,
    S_WRITE
  } state_e;

  // Instruction layout: opcode | dest | src1 | src2/imm
  localparam int FIELD_W  = 8;
  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  localparam int IMM_LSB  = 0;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // Legal opcodes form the contiguous range LOADI..OR.
  function automatic logic op_legal(
    input logic [7:0] op
  );
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/reg_access_sequencer_if.sv
// Instruction handshake plus register-file bus of the sequencer.
// master: sequencer side; slave: instruction source / register file.
interface reg_access_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);

  logic [31:0]       INSTR;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [ADDR_W-1:0] RF_OUT1ADDR;
  logic [ADDR_W-1:0] RF_OUT2ADDR;
  logic [DATA_W-1:0] RF_OUT1;
  logic [DATA_W-1:0] RF_OUT2;
  logic [ADDR_W-1:0] RF_INADDR;
  logic [DATA_W-1:0] RF_IN;
  logic              RF_WE;
  logic [DATA_W-1:0] RESULT;
  logic              DONE;
  logic              ERR;

  modport master (
    input  INSTR, INSTR_VALID,
    input  RF_OUT1, RF_OUT2,
    output INSTR_READY,
    output RF_OUT1ADDR, RF_OUT2ADDR,
    output RF_INADDR, RF_IN, RF_WE,
    output RESULT, DONE, ERR
  );

  modport slave (
    output INSTR, INSTR_VALID,
    output RF_OUT1, RF_OUT2,
    input  INSTR_READY,
    input  RF_OUT1ADDR, RF_OUT2ADDR,
    input  RF_INADDR, RF_IN, RF_WE,
    input  RESULT, DONE, ERR
  );

endinterface

// File: rtl/seq_alu.sv
// Combinational sequencer ALU: op_i, a_i, b_i -> res_o (DATA_W wrap).
// LOADI and MOV both forward b_i (immediate or src2 operand).
module seq_alu
  import reg_access_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_LOADI,
      OP_MOV:  res_o = b_i;
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// Register-access sequencer: accepts one instruction, reads operands,
// executes and writes back. Ports: CLK, RESET, bus (master modport).
module reg_access_sequencer
  import reg_access_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic CLK,
  input logic RESET,
  reg_access_sequencer_if.master bus
);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] s1_q, s1_d;
  logic [ADDR_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] alu_res;
  logic [7:0]        in_op;

  assign in_op = bus.INSTR[OPC_LSB +: FIELD_W];

  seq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .res_o(alu_res)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.INSTR_VALID) begin
          op_d  = in_op;
          dst_d = bus.INSTR[DST_LSB +: ADDR_W];
          s1_d  = bus.INSTR[SRC1_LSB +: ADDR_W];
          s2_d  = bus.INSTR[SRC2_LSB +: ADDR_W];
          if (!op_legal(in_op)) begin
            err_d = 1'b1;
          end else if (in_op == OP_LOADI) begin
            // Immediate rides through the ALU b operand.
            b_d     = DATA_W'(bus.INSTR[IMM_LSB +: FIELD_W]);
            state_d = S_EXEC;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        // Read data lags the address by one cycle.
        a_d     = bus.RF_OUT1;
        b_d     = bus.RF_OUT2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.INSTR_READY = (state_q == S_IDLE);
    bus.RF_OUT1ADDR = '0;
    bus.RF_OUT2ADDR = '0;
    bus.RF_INADDR   = '0;
    bus.RF_IN       = '0;
    bus.RF_WE       = 1'b0;
    bus.DONE        = 1'b0;
    bus.RESULT      = res_q;
    bus.ERR         = err_q;
    case (state_q)
      S_READ,
      S_WAIT: begin
        bus.RF_OUT1ADDR = s1_q;
        bus.RF_OUT2ADDR = s2_q;
      end
      S_WRITE: begin
        bus.RF_WE     = 1'b1;
        bus.RF_INADDR = dst_q;
        bus.RF_IN     = res_q;
        bus.DONE      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Directed self-checking bench for reg_access_sequencer.
// Provides a registered-read register file behind the slave modport.
module tb_reg_access_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  reg_access_sequencer_if #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) bus ();

  reg_access_sequencer #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp    = 0;
  int n_bad    = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;
  logic [10:0] wr_log[$];

  logic [7:0] rf[8] = '{default: 8'h00};

  always @(posedge CLK) begin
    if (bus.RF_WE === 1'b1) rf[bus.RF_INADDR] <= bus.RF_IN;
    bus.RF_OUT1 <= rf[bus.RF_OUT1ADDR];
    bus.RF_OUT2 <= rf[bus.RF_OUT2ADDR];
  end

  always @(negedge CLK) begin
    if (bus.RF_WE === 1'b1) begin
      wr_cnt++;
      wr_log.push_back({bus.RF_INADDR, bus.RF_IN});
    end
    if (bus.DONE === 1'b1 && bus.ERR === 1'b1) both_cnt++;
  end

  function automatic logic [31:0] mk(
    input logic [7:0] op, input logic [7:0] d,
    input logic [7:0] s1, input logic [7:0] s2
  );
    return {op, d, s1, s2};
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] ins);
    int n;
    n = 0;
    bus.INSTR = ins;
    bus.INSTR_VALID = 1'b1;
    while (bus.INSTR_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL send_ready: ready=%b need 1", bus.INSTR_READY);
    end
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    bus.INSTR = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset;
    bus.INSTR = '0;
    bus.INSTR_VALID = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    n_cmp++;
    if (bus.INSTR_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b need 1", bus.INSTR_READY);
    end
    n_cmp++;
    if ({bus.RF_WE, bus.DONE, bus.ERR} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_strobes: got %b need 000",
               {bus.RF_WE, bus.DONE, bus.ERR});
    end
    n_cmp++;
    if ({bus.RESULT, bus.RF_IN} !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_data: got %h need 0000",
               {bus.RESULT, bus.RF_IN});
    end
    n_cmp++;
    if ({bus.RF_OUT1ADDR, bus.RF_OUT2ADDR, bus.RF_INADDR} !== 9'h0) begin
      n_bad++;
      $display("FAIL rst_addr: got %h need 0",
               {bus.RF_OUT1ADDR, bus.RF_OUT2ADDR, bus.RF_INADDR});
    end
  endtask

  task automatic test_loadi;
    send(mk(8'h00, 8'd2, 8'd0, 8'h20));
    n_cmp++;
    if ({bus.RF_WE, bus.DONE} !== 2'b00) begin
      n_bad++;
      $display("FAIL loadi_exec: we,done=%b need 00",
               {bus.RF_WE, bus.DONE});
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN} !==
        {2'b11, 3'd2, 8'h20}) begin
      n_bad++;
      $display("FAIL loadi_write: we=%b done=%b a=%0d d=%h need 1 1 2 20",
               bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN);
    end
    n_cmp++;
    if (bus.RESULT !== 8'h20) begin
      n_bad++;
      $display("FAIL loadi_result: got %h need 20", bus.RESULT);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.INSTR_READY, bus.DONE, bus.RF_WE, bus.RESULT} !==
        {3'b100, 8'h20}) begin
      n_bad++;
      $display("FAIL loadi_idle: rdy=%b done=%b we=%b res=%h need 1 0 0 20",
               bus.INSTR_READY, bus.DONE, bus.RF_WE, bus.RESULT);
    end
    send(mk(8'h00, 8'd1, 8'd0, 8'h16));
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_add;
    send(mk(8'h02, 8'd3, 8'd1, 8'd2));
    n_cmp++;
    if ({bus.RF_OUT1ADDR, bus.RF_OUT2ADDR, bus.RF_WE} !==
        {3'd1, 3'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL add_read: a1=%0d a2=%0d we=%b need 1 2 0",
               bus.RF_OUT1ADDR, bus.RF_OUT2ADDR, bus.RF_WE);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.RF_OUT1ADDR, bus.RF_OUT2ADDR} !== {3'd1, 3'd2}) begin
      n_bad++;
      $display("FAIL add_wait: a1=%0d a2=%0d need 1 2",
               bus.RF_OUT1ADDR, bus.RF_OUT2ADDR);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.RF_WE, bus.DONE} !== 2'b00) begin
      n_bad++;
      $display("FAIL add_exec: we,done=%b need 00",
               {bus.RF_WE, bus.DONE});
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN, bus.RESULT} !==
        {2'b11, 3'd3, 8'h36, 8'h36}) begin
      n_bad++;
      $display("FAIL add_write: we=%b done=%b a=%0d d=%h r=%h need 1 1 3 36 36",
               bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN, bus.RESULT);
    end
    @(negedge CLK);
  endtask

  task automatic test_regops;
    logic [31:0] ins[5];
    logic [2:0]  dst[5];
    logic [7:0]  exp[5];
    ins[0] = mk(8'h03, 8'd4, 8'd1, 8'd2); dst[0] = 3'd4; exp[0] = 8'hF6;
    ins[1] = mk(8'h04, 8'd5, 8'd3, 8'd1); dst[1] = 3'd5; exp[1] = 8'h16;
    ins[2] = mk(8'h05, 8'd6, 8'd1, 8'd2); dst[2] = 3'd6; exp[2] = 8'h36;
    ins[3] = mk(8'h01, 8'd7, 8'd0, 8'd2); dst[3] = 3'd7; exp[3] = 8'h20;
    ins[4] = mk(8'h02, 8'd1, 8'd1, 8'd1); dst[4] = 3'd1; exp[4] = 8'h2C;
    for (int i = 0; i < 5; i++) begin
      send(ins[i]);
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ({bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN, bus.RESULT} !==
          {2'b11, dst[i], exp[i], exp[i]}) begin
        n_bad++;
        $display("FAIL regop%0d: we=%b done=%b a=%0d d=%h r=%h need 1 1 %0d %h",
                 i, bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN,
                 bus.RESULT, dst[i], exp[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_illegal;
    int w0;
    w0 = wr_cnt;
    send(mk(8'h07, 8'd3, 8'd1, 8'd2));
    n_cmp++;
    if ({bus.ERR, bus.DONE, bus.RF_WE, bus.INSTR_READY} !== 4'b1001) begin
      n_bad++;
      $display("FAIL illegal_pulse: err=%b done=%b we=%b rdy=%b need 1 0 0 1",
               bus.ERR, bus.DONE, bus.RF_WE, bus.INSTR_READY);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_once: err=%b need 0", bus.ERR);
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (wr_cnt !== w0) begin
      n_bad++;
      $display("FAIL illegal_nowrite: writes=%0d need %0d", wr_cnt, w0);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    w0 = wr_cnt;
    send(mk(8'h02, 8'd2, 8'd1, 8'd1));
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    n_cmp++;
    if ({bus.INSTR_READY, bus.RF_WE, bus.DONE, bus.ERR} !== 4'b1000) begin
      n_bad++;
      $display("FAIL midrst_ctl: rdy=%b we=%b done=%b err=%b need 1 0 0 0",
               bus.INSTR_READY, bus.RF_WE, bus.DONE, bus.ERR);
    end
    n_cmp++;
    if ({bus.RESULT, bus.RF_IN, bus.RF_OUT1ADDR, bus.RF_OUT2ADDR} !==
        22'h0) begin
      n_bad++;
      $display("FAIL midrst_data: res=%h in=%h a1=%0d a2=%0d need 0",
               bus.RESULT, bus.RF_IN, bus.RF_OUT1ADDR, bus.RF_OUT2ADDR);
    end
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (wr_cnt !== w0 || rf[2] !== 8'h20) begin
      n_bad++;
      $display("FAIL midrst_nowrite: writes=%0d r2=%h need %0d 20",
               wr_cnt, rf[2], w0);
    end
    send(mk(8'h00, 8'd0, 8'd0, 8'h5A));
    @(negedge CLK);
    n_cmp++;
    if ({bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN} !==
        {2'b11, 3'd0, 8'h5A}) begin
      n_bad++;
      $display("FAIL midrst_loadi: we=%b done=%b a=%0d d=%h need 1 1 0 5a",
               bus.RF_WE, bus.DONE, bus.RF_INADDR, bus.RF_IN);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog[3];
    logic [10:0] exp[3];
    int acc_at[3];
    int idx;
    prog[0] = mk(8'h00, 8'd5, 8'd0, 8'h11);
    prog[1] = mk(8'h00, 8'd6, 8'd0, 8'h22);
    prog[2] = mk(8'h02, 8'd7, 8'd5, 8'd6);
    exp[0] = {3'd5, 8'h11};
    exp[1] = {3'd6, 8'h22};
    exp[2] = {3'd7, 8'h33};
    idx = 0;
    wr_log.delete();
    for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
      bus.INSTR = prog[idx];
      bus.INSTR_VALID = 1'b1;
      if (bus.INSTR_READY === 1'b1) begin
        acc_at[idx] = cyc;
        idx++;
      end
      @(negedge CLK);
    end
    bus.INSTR_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    n_cmp++;
    if (idx != 3) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %0d need 3", idx);
    end else begin
      n_cmp++;
      if (acc_at[1] - acc_at[0] != 3 || acc_at[2] - acc_at[1] != 3) begin
        n_bad++;
        $display("FAIL b2b_spacing: gaps %0d %0d need 3 3",
                 acc_at[1] - acc_at[0], acc_at[2] - acc_at[1]);
      end
    end
    n_cmp++;
    if (wr_log.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_nwrites: got %0d need 3", wr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wr_log[i] !== exp[i]) begin
          n_bad++;
          $display("FAIL b2b_write%0d: got %h need %h",
                   i, wr_log[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    bus.INSTR = '0;
    bus.INSTR_VALID = 1'b0;
    test_reset();
    test_loadi();
    test_add();
    test_regops();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (both_cnt != 0) begin
      n_bad++;
      $display("FAIL done_err_overlap: got %0d need 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
